// File: rtl/fsk_pcm_rx_demod_if.sv
// Handshake/bus bundle between the FSK line front end and the character framer.
interface fsk_pcm_rx_demod_if #(
  parameter int unsigned FRAME_BITS = 14
);
  logic                  fsk_in;
  logic                  rx_bit;
  logic                  rx_bit_valid;
  logic [FRAME_BITS-1:0] frame_data;
  logic                  frame_valid;
  logic                  frame_err;
  logic                  busy;

  modport master (
    output fsk_in,
    input  rx_bit, rx_bit_valid, frame_data, frame_valid, frame_err, busy
  );

  modport slave (
    input  fsk_in,
    output rx_bit, rx_bit_valid, frame_data, frame_valid, frame_err, busy
  );
endinterface

// File: rtl/fsk_pcm_rx_demod.sv
// Binary FSK demodulator: classifies each bit window by edge density and
// frames 14-bit characters for the downstream Hamming decoder.
module fsk_pcm_rx_demod #(
  parameter int unsigned BIT_CYC    = 32,
  parameter int unsigned FRAME_BITS = 14,
  parameter int unsigned IDLE_CYC   = 64,
  parameter int unsigned ONE_MIN    = 28,
  parameter int unsigned ZERO_MIN   = 12,
  parameter int unsigned ZERO_MAX   = 20,
  parameter int unsigned DECIDE_TH  = 24
) (
  input logic               clkIn,
  input logic               reset,
  fsk_pcm_rx_demod_if.slave bus
);

  localparam int unsigned WIN_W  = $clog2(BIT_CYC);
  localparam int unsigned ECNT_W = 7;
  localparam int unsigned IDLE_W = $clog2(IDLE_CYC + 1);
  localparam int unsigned BIDX_W = $clog2(FRAME_BITS);

  typedef enum logic [1:0] {HUNT, ARMED, RUN} state_t;

  state_t                  state_q, state_d;
  logic [2:0]              sync_q;
  logic [IDLE_W-1:0]       idle_q, idle_d;
  logic [WIN_W-1:0]        win_q, win_d;
  logic [ECNT_W-1:0]       ecnt_q, ecnt_d;
  logic [BIDX_W-1:0]       bidx_q, bidx_d;
  logic [FRAME_BITS-2:0]   shift_q, shift_d;
  logic                    err_q, err_d;
  logic                    zero_q, zero_d;
  logic                    rx_bit_q, rx_bit_d;
  logic                    rx_bit_valid_q, rx_bit_valid_d;
  logic [FRAME_BITS-1:0]   frame_data_q, frame_data_d;
  logic                    frame_valid_q, frame_valid_d;
  logic                    frame_err_q, frame_err_d;
  logic                    busy_q, busy_d;

  logic                    edge_c;
  logic [ECNT_W-1:0]       total_c;
  logic                    one_c, zero_ok_c, amb_c, bit_c, err_now_c, zero_now_c;

  // Two synchroniser stages, third stage only for edge detection
  always_ff @(posedge clkIn or posedge reset) begin
    if (reset) sync_q <= 3'b000;
    else       sync_q <= {sync_q[1:0], bus.fsk_in};
  end

  assign edge_c = sync_q[1] ^ sync_q[2];

  always_ff @(posedge clkIn or posedge reset) begin
    if (reset) begin
      state_q        <= HUNT;
      idle_q         <= '0;
      win_q          <= '0;
      ecnt_q         <= '0;
      bidx_q         <= '0;
      shift_q        <= '0;
      err_q          <= 1'b0;
      zero_q         <= 1'b0;
      rx_bit_q       <= 1'b0;
      rx_bit_valid_q <= 1'b0;
      frame_data_q   <= '0;
      frame_valid_q  <= 1'b0;
      frame_err_q    <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      idle_q         <= idle_d;
      win_q          <= win_d;
      ecnt_q         <= ecnt_d;
      bidx_q         <= bidx_d;
      shift_q        <= shift_d;
      err_q          <= err_d;
      zero_q         <= zero_d;
      rx_bit_q       <= rx_bit_d;
      rx_bit_valid_q <= rx_bit_valid_d;
      frame_data_q   <= frame_data_d;
      frame_valid_q  <= frame_valid_d;
      frame_err_q    <= frame_err_d;
      busy_q         <= busy_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    idle_d         = idle_q;
    win_d          = win_q;
    ecnt_d         = ecnt_q;
    bidx_d         = bidx_q;
    shift_d        = shift_q;
    err_d          = err_q;
    zero_d         = zero_q;
    rx_bit_d       = rx_bit_q;
    rx_bit_valid_d = 1'b0;
    frame_data_d   = frame_data_q;
    frame_valid_d  = 1'b0;
    frame_err_d    = frame_err_q;

    // Window total includes the edge seen in the current cycle
    total_c    = ecnt_q + ECNT_W'(edge_c);
    one_c      = total_c >= ECNT_W'(ONE_MIN);
    zero_ok_c  = (total_c >= ECNT_W'(ZERO_MIN)) && (total_c <= ECNT_W'(ZERO_MAX));
    amb_c      = !one_c && !zero_ok_c;
    bit_c      = one_c || (amb_c && (total_c >= ECNT_W'(DECIDE_TH)));
    err_now_c  = err_q || amb_c;
    zero_now_c = (total_c == '0);

    case (state_q)
      HUNT: begin
        if (edge_c)                          idle_d = '0;
        else if (idle_q < IDLE_W'(IDLE_CYC)) idle_d = idle_q + IDLE_W'(1);
        if (idle_q == IDLE_W'(IDLE_CYC))     state_d = ARMED;
      end
      ARMED: begin
        if (edge_c) begin
          state_d = RUN;
          win_d   = WIN_W'(1);
          ecnt_d  = ECNT_W'(1);
          bidx_d  = '0;
          err_d   = 1'b0;
          zero_d  = 1'b0;
        end
      end
      RUN: begin
        if (win_q == WIN_W'(BIT_CYC - 1)) begin
          rx_bit_d       = bit_c;
          rx_bit_valid_d = 1'b1;
          win_d          = '0;
          ecnt_d         = '0;
          shift_d        = {shift_q[FRAME_BITS-3:0], bit_c};
          zero_d         = zero_now_c;
          // Two silent windows in a row: carrier lost, drop the character
          if (zero_q && zero_now_c) begin
            state_d = HUNT;
            idle_d  = '0;
          end else if (bidx_q == BIDX_W'(FRAME_BITS - 1)) begin
            frame_data_d  = {shift_q, bit_c};
            frame_err_d   = err_now_c;
            frame_valid_d = 1'b1;
            bidx_d        = '0;
            err_d         = 1'b0;
            if (err_now_c) begin
              state_d = HUNT;
              idle_d  = '0;
            end
          end else begin
            bidx_d = bidx_q + BIDX_W'(1);
            err_d  = err_now_c;
          end
        end else begin
          win_d  = win_q + WIN_W'(1);
          ecnt_d = total_c;
        end
      end
      default: state_d = HUNT;
    endcase

    busy_d = (state_d == RUN);
  end

  assign bus.rx_bit       = rx_bit_q;
  assign bus.rx_bit_valid = rx_bit_valid_q;
  assign bus.frame_data   = frame_data_q;
  assign bus.frame_valid  = frame_valid_q;
  assign bus.frame_err    = frame_err_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_fsk_pcm_rx_demod.sv
// Directed bench for the FSK demodulator/framer: clean, back-to-back,
// ambiguous-window, carrier-loss and mid-frame reset scenarios.
module tb_fsk_pcm_rx_demod;

  logic clkIn = 1'b0;
  logic reset = 1'b1;
  always #5 clkIn = ~clkIn;

  fsk_pcm_rx_demod_if bus ();

  fsk_pcm_rx_demod dut (
    .clkIn (clkIn),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  logic lvl = 1'b0;

  // Negedge monitor: strobe counts, spacing, and snapshots at each frame_valid
  int cyc = 0, rx_cnt = 0, fv_cnt = 0, bad_gap = 0, busy_fall = 0, fv_no_rx = 0;
  int last_rx_cyc = -1000;
  int fv_last_cyc = 0, fv_prev_cyc = 0, fv_last_bf = 0, fv_prev_bf = 0;
  logic [13:0] rx_hist = '0, fv_rx_hist = '0;
  logic [13:0] fv_last_data = '0, fv_prev_data = '0;
  logic fv_last_err = 1'b0, busy_prev = 1'b0;

  always @(negedge clkIn) begin
    cyc++;
    if (bus.rx_bit_valid === 1'b1) begin
      if ((cyc - last_rx_cyc) <= 64 && (cyc - last_rx_cyc) != 32) bad_gap++;
      last_rx_cyc = cyc;
      rx_cnt++;
      rx_hist = {rx_hist[12:0], bus.rx_bit};
    end
    if (bus.frame_valid === 1'b1) begin
      fv_prev_cyc  = fv_last_cyc;  fv_last_cyc  = cyc;
      fv_prev_data = fv_last_data; fv_last_data = bus.frame_data;
      fv_prev_bf   = fv_last_bf;   fv_last_bf   = busy_fall;
      fv_last_err  = bus.frame_err;
      fv_rx_hist   = rx_hist;
      fv_cnt++;
      if (bus.rx_bit_valid !== 1'b1) fv_no_rx++;
    end
    if (busy_prev && (bus.busy !== 1'b1)) busy_fall++;
    busy_prev = (bus.busy === 1'b1);
  end

  task automatic quiet(input int n);
    repeat (n) begin
      @(posedge clkIn); #1;
      bus.fsk_in = lvl;
    end
  endtask

  // One bit window with exactly n line toggles, the first on window cycle 0
  task automatic send_window(input int n);
    for (int i = 0; i < 32; i++) begin
      @(posedge clkIn); #1;
      if (((i * n) % 32) < n) lvl = ~lvl;
      bus.fsk_in = lvl;
    end
  endtask

  task automatic send_frame(input logic [13:0] d, input int amb_idx, input int nbits);
    for (int b = 0; b < nbits; b++)
      send_window((b == amb_idx) ? 22 : (d[13-b] ? 32 : 16));
  endtask

  task automatic test_reset;
    int rx0, fv0;
    bus.fsk_in = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clkIn);
    @(negedge clkIn);
    checks++; if (bus.frame_data !== 14'h0000) begin errors++; $display("FAIL reset_frame_data got %h want 0000", bus.frame_data); end
    checks++; if ({bus.rx_bit, bus.rx_bit_valid, bus.frame_valid, bus.frame_err, bus.busy} !== 5'b0) begin
      errors++; $display("FAIL reset_outputs got %b want 00000", {bus.rx_bit, bus.rx_bit_valid, bus.frame_valid, bus.frame_err, bus.busy}); end
    reset = 1'b0;
    rx0 = rx_cnt; fv0 = fv_cnt;
    quiet(100);
    @(negedge clkIn);
    checks++; if ((rx_cnt - rx0) !== 0 || (fv_cnt - fv0) !== 0) begin
      errors++; $display("FAIL idle_strobes got rx=%0d fv=%0d want 0 0", rx_cnt - rx0, fv_cnt - fv0); end
    checks++; if (dut.idle_q !== 7'd64) begin errors++; $display("FAIL idle_saturate got %0d want 64", dut.idle_q); end
    checks++; if (bus.busy !== 1'b0 || bus.frame_data !== 14'h0000) begin
      errors++; $display("FAIL idle_outputs got busy=%b data=%h want 0 0000", bus.busy, bus.frame_data); end
  endtask

  task automatic test_clean_frame;
    int rx0, fv0, bg0;
    quiet(70);
    rx0 = rx_cnt; fv0 = fv_cnt; bg0 = bad_gap;
    send_frame(14'h2CE5, -1, 14);
    quiet(8);
    checks++; if ((fv_cnt - fv0) !== 1) begin errors++; $display("FAIL clean_fv_count got %0d want 1", fv_cnt - fv0); end
    checks++; if (fv_last_data !== 14'h2CE5) begin errors++; $display("FAIL clean_data got %h want 2ce5", fv_last_data); end
    checks++; if (fv_last_err !== 1'b0) begin errors++; $display("FAIL clean_err got %b want 0", fv_last_err); end
    checks++; if (fv_rx_hist !== 14'h2CE5) begin errors++; $display("FAIL clean_rx_bits got %h want 2ce5", fv_rx_hist); end
    checks++; if ((rx_cnt - rx0) !== 14) begin errors++; $display("FAIL clean_rx_count got %0d want 14", rx_cnt - rx0); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL clean_busy_after got %b want 1", bus.busy); end
    // Line now silent: two empty windows end the run
    quiet(200);
    checks++; if ((rx_cnt - rx0) !== 16) begin errors++; $display("FAIL silent_abort_rx got %0d want 16", rx_cnt - rx0); end
    checks++; if (bad_gap !== bg0) begin errors++; $display("FAIL clean_spacing got %0d bad gaps want 0", bad_gap - bg0); end
    checks++; if (bus.busy !== 1'b0 || bus.frame_data !== 14'h2CE5) begin
      errors++; $display("FAIL silent_abort_state got busy=%b data=%h want 0 2ce5", bus.busy, bus.frame_data); end
  endtask

  task automatic test_back_to_back;
    int fv0;
    quiet(20);
    fv0 = fv_cnt;
    send_frame(14'h2CE5, -1, 14);
    send_frame(14'h1A53, -1, 14);
    quiet(8);
    checks++; if ((fv_cnt - fv0) !== 2) begin errors++; $display("FAIL b2b_fv_count got %0d want 2", fv_cnt - fv0); end
    checks++; if ((fv_last_cyc - fv_prev_cyc) !== 448) begin errors++; $display("FAIL b2b_gap got %0d want 448", fv_last_cyc - fv_prev_cyc); end
    checks++; if (fv_prev_data !== 14'h2CE5 || fv_last_data !== 14'h1A53) begin
      errors++; $display("FAIL b2b_data got %h %h want 2ce5 1a53", fv_prev_data, fv_last_data); end
    checks++; if (fv_last_bf !== fv_prev_bf) begin errors++; $display("FAIL b2b_busy got %0d drops want 0", fv_last_bf - fv_prev_bf); end
    checks++; if (fv_no_rx !== 0) begin errors++; $display("FAIL fv_with_rx got %0d orphan strobes want 0", fv_no_rx); end
    quiet(200);
  endtask

  task automatic test_err_frame;
    int rx0, fv0;
    quiet(20);
    fv0 = fv_cnt;
    send_frame(14'h3FFF, 5, 14);
    quiet(8);
    checks++; if ((fv_cnt - fv0) !== 1) begin errors++; $display("FAIL err_fv_count got %0d want 1", fv_cnt - fv0); end
    checks++; if (fv_last_data !== 14'h3EFF) begin errors++; $display("FAIL err_data got %h want 3eff", fv_last_data); end
    checks++; if (fv_last_err !== 1'b1 || bus.frame_err !== 1'b1) begin
      errors++; $display("FAIL err_flag got %b/%b want 1/1", fv_last_err, bus.frame_err); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL err_busy got %b want 0", bus.busy); end
    // Not enough quiet time to re-arm, so this frame must be ignored
    rx0 = rx_cnt; fv0 = fv_cnt;
    send_frame(14'h1A53, -1, 14);
    quiet(10);
    checks++; if ((rx_cnt - rx0) !== 0 || (fv_cnt - fv0) !== 0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL err_ignore got rx=%0d fv=%0d busy=%b want 0 0 0", rx_cnt - rx0, fv_cnt - fv0, bus.busy); end
  endtask

  task automatic test_abort;
    int rx0, fv0;
    quiet(200);
    rx0 = rx_cnt; fv0 = fv_cnt;
    send_frame(14'h2CE5, -1, 4);
    quiet(80);
    checks++; if ((rx_cnt - rx0) !== 6) begin errors++; $display("FAIL abort_rx_count got %0d want 6", rx_cnt - rx0); end
    checks++; if ((fv_cnt - fv0) !== 0) begin errors++; $display("FAIL abort_fv got %0d want 0", fv_cnt - fv0); end
    checks++; if (bus.frame_data !== 14'h3EFF || bus.frame_err !== 1'b1) begin
      errors++; $display("FAIL abort_hold got %h/%b want 3eff/1", bus.frame_data, bus.frame_err); end
    checks++; if (bus.busy !== 1'b0 || bus.rx_bit !== 1'b0) begin
      errors++; $display("FAIL abort_state got busy=%b bit=%b want 0 0", bus.busy, bus.rx_bit); end
    quiet(70);
    checks++; if (dut.idle_q !== 7'd64) begin errors++; $display("FAIL abort_rearm got %0d want 64", dut.idle_q); end
  endtask

  task automatic test_reset_mid;
    int fv0;
    quiet(10);
    send_frame(14'h1A53, -1, 9);
    quiet(5);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b want 1", bus.busy); end
    @(negedge clkIn);
    reset = 1'b1;
    #1;
    checks++; if ({bus.frame_data, bus.rx_bit, bus.rx_bit_valid, bus.frame_valid, bus.frame_err, bus.busy} !== 19'h0) begin
      errors++; $display("FAIL mid_reset_outputs got data=%h busy=%b err=%b want 0", bus.frame_data, bus.busy, bus.frame_err); end
    lvl = 1'b0;
    bus.fsk_in = 1'b0;
    repeat (2) @(posedge clkIn);
    @(negedge clkIn);
    reset = 1'b0;
    quiet(70);
    fv0 = fv_cnt;
    send_frame(14'h1A53, -1, 14);
    quiet(8);
    checks++; if ((fv_cnt - fv0) !== 1 || fv_last_data !== 14'h1A53 || fv_last_err !== 1'b0) begin
      errors++; $display("FAIL post_reset_frame got n=%0d data=%h err=%b want 1 1a53 0", fv_cnt - fv0, fv_last_data, fv_last_err); end
  endtask

  initial begin
    bus.fsk_in = 1'b0;
    test_reset();
    test_clean_frame();
    test_back_to_back();
    test_err_frame();
    test_abort();
    test_reset_mid();
    quiet(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
